// File: rtl/ps2_device_phy.sv
// Device-side PS/2 line engine: drives the bus clock, shifts device frames out,
// and receives host command frames (with ACK) after a host request-to-send.
module ps2_device_phy #(
   parameter int QUARTER_CYCLES = 1000,
   parameter int IDLE_CYCLES    = 2500
) (
   input  logic       clk,
   input  logic       rst_n,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_abort,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_parity_err,
   output logic       rx_frame_err
);

   localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
   localparam int IW = $clog2(IDLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_RX,
      S_ACK,
      S_RECOVER
   } state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [3:0]    slot_q, slot_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [10:0]   frame_q, frame_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          tx_done_q, tx_done_d;
   logic          tx_abort_q, tx_abort_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_perr_q, rx_perr_d;
   logic          rx_ferr_q, rx_ferr_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          lines_hi, rts, q_end, mid_slot, slot_end, in_frame_d;

   assign ps2_clk  = clk_oe_q ? 1'b0 : 1'bz;
   assign ps2_data = dat_oe_q ? 1'b0 : 1'bz;

   // Synchronizers reset low: idle time only accrues once the bus is actually seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q <= 1'b0;
         clk_s2_q <= 1'b0;
         dat_s1_q <= 1'b0;
         dat_s2_q <= 1'b0;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign lines_hi = clk_s2_q & dat_s2_q;
   assign rts      = clk_s2_q & ~dat_s2_q;
   assign q_end    = (qcnt_q == QW'(QUARTER_CYCLES - 1));
   assign mid_slot = q_end & (quarter_q == 2'd1);
   assign slot_end = q_end & (quarter_q == 2'd3);

   always_comb begin
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      quarter_d  = quarter_q;
      slot_d     = slot_q;
      idle_d     = idle_q;
      frame_d    = frame_q;
      dat_oe_d   = dat_oe_q;
      rx_data_d  = rx_data_q;
      tx_done_d  = 1'b0;
      tx_abort_d = 1'b0;
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      tx_ready   = 1'b0;
      in_frame_d = 1'b0;
      clk_oe_d   = 1'b0;

      if (state_q == S_TX || state_q == S_RX || state_q == S_ACK) begin
         if (q_end) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + QW'(1);
         end
      end else begin
         qcnt_d    = '0;
         quarter_d = 2'd0;
         slot_d    = 4'd0;
      end

      case (state_q)
         S_IDLE: begin
            if (lines_hi) begin
               if (idle_q != IW'(IDLE_CYCLES)) idle_d = idle_q + IW'(1);
            end else begin
               idle_d = '0;
            end
            tx_ready = (idle_q >= IW'(IDLE_CYCLES)) & ~rts;
            if (rts) begin
               state_d = S_RX;
            end else if (tx_valid && tx_ready) begin
               frame_d  = {1'b1, ~^tx_data, tx_data, 1'b0};
               dat_oe_d = 1'b1;
               state_d  = S_TX;
            end
         end
         S_TX: begin
            // Host holding the clock low while we have it released means inhibit.
            if (mid_slot && !clk_s2_q) begin
               dat_oe_d   = 1'b0;
               tx_abort_d = 1'b1;
               state_d    = S_RECOVER;
            end else if (slot_end) begin
               if (slot_q == 4'd10) begin
                  dat_oe_d  = 1'b0;
                  tx_done_d = 1'b1;
                  state_d   = S_RECOVER;
               end else begin
                  slot_d   = slot_q + 4'd1;
                  frame_d  = {1'b1, frame_q[10:1]};
                  dat_oe_d = ~frame_q[1];
               end
            end
         end
         S_RX: begin
            // Shifted in from the top so d0..stop land in the same bit positions as a TX frame.
            if (mid_slot && slot_q != 4'd0) frame_d = {dat_s2_q, frame_q[10:1]};
            if (slot_end) begin
               if (slot_q == 4'd10) begin
                  slot_d = 4'd0;
                  if (!frame_q[10]) begin
                     rx_ferr_d = 1'b1;
                     state_d   = S_RECOVER;
                  end else begin
                     dat_oe_d = 1'b1;
                     state_d  = S_ACK;
                  end
               end else begin
                  slot_d = slot_q + 4'd1;
               end
            end
         end
         S_ACK: begin
            if (slot_end) begin
               dat_oe_d   = 1'b0;
               rx_valid_d = 1'b1;
               rx_data_d  = frame_q[8:1];
               rx_perr_d  = ~^frame_q[9:1];
               state_d    = S_RECOVER;
            end
         end
         S_RECOVER: begin
            idle_d = '0;
            if (lines_hi) state_d = S_IDLE;
         end
         default: begin
            dat_oe_d = 1'b0;
            state_d  = S_RECOVER;
         end
      endcase

      in_frame_d = (state_d == S_TX) || (state_d == S_RX) || (state_d == S_ACK);
      clk_oe_d   = in_frame_d & quarter_d[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         qcnt_q     <= '0;
         quarter_q  <= 2'd0;
         slot_q     <= 4'd0;
         idle_q     <= '0;
         frame_q    <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         tx_done_q  <= 1'b0;
         tx_abort_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         quarter_q  <= quarter_d;
         slot_q     <= slot_d;
         idle_q     <= idle_d;
         frame_q    <= frame_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         tx_done_q  <= tx_done_d;
         tx_abort_q <= tx_abort_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign tx_done       = tx_done_q;
   assign tx_abort      = tx_abort_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_data       = rx_data_q;

endmodule

// File: tb/tb_ps2_device_phy.sv
// Bench for ps2_device_phy: a host model on pulled-up open-drain lines sends and
// receives frames built from the PS/2 framing rules.
module tb_ps2_device_phy;

   localparam int Q    = 8;
   localparam int IDLE = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   wire        ps2_clk;
   wire        ps2_data;
   logic       host_clk_low = 1'b0;
   logic       host_dat_low = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_abort, rx_valid, rx_parity_err, rx_frame_err;
   logic [7:0] rx_data;

   int checks = 0;
   int errors = 0;
   int n_done = 0, n_abort = 0, n_rxv = 0, n_ferr = 0, n_overlap = 0;

   assign ps2_clk  = host_clk_low ? 1'b0 : 1'bz;
   assign ps2_data = host_dat_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   always #5 clk = ~clk;

   ps2_device_phy #(.QUARTER_CYCLES(Q), .IDLE_CYCLES(IDLE)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .tx_done(tx_done), .tx_abort(tx_abort), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         n_done  <= n_done + int'(tx_done);
         n_abort <= n_abort + int'(tx_abort);
         n_rxv   <= n_rxv + int'(rx_valid);
         n_ferr  <= n_ferr + int'(rx_frame_err);
         if (int'(tx_done) + int'(tx_abort) + int'(rx_valid) + int'(rx_frame_err) > 1)
            n_overlap <= n_overlap + 1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts edges from a point between edges; tx_ready must rise on exactly edge n.
   task automatic ready_window(input string tag, input int n);
      logic lines_ok;
      lines_ok = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) lines_ok = 1'b0;
         if (i == n - 1) chk({tag, "_ready_early"}, tx_ready, 0);
         if (i == n)     chk({tag, "_ready_rise"}, tx_ready, 1);
      end
      chk({tag, "_lines_released"}, lines_ok, 1);
   endtask

   // mode 0: full frame; 1: host inhibits in slot 4 Q0; 2: reset asserted in slot 6
   task automatic tx_frame(input logic [7:0] b, input int mode);
      logic [10:0] exp_bits, seen;
      logic        prev, ok, holding;
      logic [1:0]  end_lines;
      int falls, low_len, lo_min, lo_max, per_min, per_max, last_fall, last_rise;
      int rise_mark, done_cyc, abort_cyc, mark_fall;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
      exp_bits[9]  = (($countones(b) % 2) == 0);
      exp_bits[10] = 1'b1;
      seen = '0; falls = 0; low_len = 0; lo_min = 1 << 30; lo_max = 0;
      per_min = 1 << 30; per_max = 0; last_fall = 0; last_rise = -1;
      rise_mark = -1; done_cyc = -1; abort_cyc = -1; holding = 1'b0; end_lines = 2'b00;
      mark_fall = (mode == 1) ? 4 : 6;

      @(negedge clk); tx_data = b; tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 4 * IDLE + 100; i++) begin
         if (tx_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("tx_ready_before_accept", ok, 1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      prev = ps2_clk;
      for (int cyc = 1; cyc <= 60 * Q; cyc++) begin
         @(negedge clk);
         if (!holding) begin
            if (prev && !ps2_clk) begin
               if (falls < 11) seen[falls] = ps2_data;
               if (falls > 0) begin
                  if (cyc - last_fall < per_min) per_min = cyc - last_fall;
                  if (cyc - last_fall > per_max) per_max = cyc - last_fall;
               end
               last_fall = cyc; falls++; low_len = 0;
            end
            if (!ps2_clk) low_len++;
            if (!prev && ps2_clk) begin
               if (low_len < lo_min) lo_min = low_len;
               if (low_len > lo_max) lo_max = low_len;
               last_rise = cyc;
               if (mode != 0 && falls == mark_fall) rise_mark = cyc;
            end
         end
         prev = ps2_clk;
         if (tx_done)  begin done_cyc = cyc;  end_lines = {ps2_clk, ps2_data}; break; end
         if (tx_abort) begin abort_cyc = cyc; end_lines = {ps2_clk, ps2_data}; break; end
         if (rise_mark > 0 && cyc == rise_mark + Q / 2) begin
            if (mode == 1) begin
               host_clk_low = 1'b1;
               holding = 1'b1;
            end else begin
               chk("tx_slot6_data_driven", ps2_data, 0);
               #1 rst_n = 1'b0;
               #1;
               chk("rst_mid_frame_clk_released", ps2_clk, 1);
               chk("rst_mid_frame_data_released", ps2_data, 1);
               chk("rst_mid_frame_ready", tx_ready, 0);
               break;
            end
         end
      end

      if (mode == 0) begin
         chk("tx_fall_count", falls, 11);
         chk("tx_bits", seen, exp_bits);
         chk("tx_low_min", lo_min, 2 * Q);
         chk("tx_low_max", lo_max, 2 * Q);
         chk("tx_period_min", per_min, 4 * Q);
         chk("tx_period_max", per_max, 4 * Q);
         chk("tx_done_seen", done_cyc > 0, 1);
         chk("tx_done_at_final_release", done_cyc, last_rise);
         chk("tx_done_lines", end_lines, 2'b11);
      end else if (mode == 1) begin
         chk("abort_seen", abort_cyc > 0, 1);
         chk("abort_slot4_q1_end", abort_cyc - rise_mark, 2 * Q);
         chk("abort_data_released", end_lines[0], 1);
         repeat (3 * Q) @(negedge clk);
         chk("abort_ready_while_inhibited", tx_ready, 0);
         host_clk_low = 1'b0;
         ready_window("abort", IDLE + 3);
      end
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic p, input logic stop);
      logic [9:0] bits;
      logic       prev, got_v, got_f, ready_seen, v_perr;
      logic [7:0] v_data;
      int falls, ack_low, ack_high;
      bits = {stop, p, b};
      falls = 0; ack_low = 0; ack_high = 0; got_v = 1'b0; got_f = 1'b0;
      ready_seen = 1'b0; v_perr = 1'b0; v_data = 8'h00;

      @(negedge clk); host_clk_low = 1'b1;
      repeat (5 * Q) @(negedge clk);
      host_dat_low = 1'b1;
      repeat (Q) @(negedge clk);
      host_clk_low = 1'b0;
      prev = 1'b1;
      for (int cyc = 1; cyc <= 70 * Q; cyc++) begin
         @(negedge clk);
         if (tx_ready) ready_seen = 1'b1;
         if (prev && !ps2_clk) begin
            falls++;
            if (falls <= 10) host_dat_low = ~bits[falls-1];
            else             host_dat_low = 1'b0;
         end
         if (falls == 12 && !ps2_clk) begin
            if (ps2_data == 1'b0) ack_low++;
            else                  ack_high++;
         end
         prev = ps2_clk;
         if (rx_valid) begin got_v = 1'b1; v_data = rx_data; v_perr = rx_parity_err; break; end
         if (rx_frame_err) begin got_f = 1'b1; break; end
      end
      host_dat_low = 1'b0;

      chk("rx_ready_held_low", ready_seen, 0);
      if (stop) begin
         chk("rx_valid_seen", got_v, 1);
         chk("rx_data", v_data, b);
         chk("rx_parity_err", v_perr, ((int'($countones(b)) + int'(p)) % 2) == 0);
         chk("rx_ack_pulses", falls, 12);
         chk("rx_ack_data_low", ack_low, 2 * Q);
         chk("rx_ack_data_high", ack_high, 0);
      end else begin
         chk("rx_frame_err_seen", got_f, 1);
         chk("rx_frame_err_no_valid", got_v, 0);
         chk("rx_frame_err_no_ack", falls, 11);
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rp;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_pulses", {tx_ready, tx_done, tx_abort, rx_valid, rx_parity_err, rx_frame_err}, 6'b0);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_lines", {ps2_clk, ps2_data}, 2'b11);
      rst_n = 1'b1;
      ready_window("powerup", IDLE + 2);

      tx_frame(8'hFA, 0);
      for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 0);
      repeat (10) @(negedge clk);

      rx_frame(8'hFF, 1'b1, 1'b1);
      rx_frame(8'hF4, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         rb = 8'($urandom);
         rp = 1'($urandom);
         rx_frame(rb, rp, 1'b1);
      end
      rx_frame(8'($urandom), 1'b0, 1'b0);

      tx_frame(8'hAA, 1);

      tx_frame(8'($urandom) & 8'hDF, 2);
      @(negedge clk);
      rst_n = 1'b1;
      ready_window("rst_mid_frame", IDLE + 2);
      tx_frame(8'($urandom), 0);
      repeat (5) @(negedge clk);

      chk("count_tx_done", n_done, 5);
      chk("count_tx_abort", n_abort, 1);
      chk("count_rx_valid", n_rxv, 5);
      chk("count_rx_frame_err", n_ferr, 1);
      chk("pulse_exclusive", n_overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
